// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into one or two 16-bit words on a valid/ready stream
// ports: clock, reset (sync, active-high); in_valid/in_ready + opcode, rd, rs1, rs2, alu_op, mem_op,
//        b_type, offset, jump_type, imm; out_valid/out_ready, out_word, out_first, out_last, out_addr; err
package instr_encoder_pkg;
    typedef enum logic [2:0] {R_TYPE, I_TYPE, B_TYPE, J_TYPE, M_TYPE, SYS_END} opcode_t;
    localparam logic [3:0] LW = 4'h1;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [15:0] START_ADDR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  opcode,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs1,
    input  logic [2:0]  rs2,
    input  logic [3:0]  alu_op,
    input  logic [3:0]  mem_op,
    input  logic [2:0]  b_type,
    input  logic [8:0]  offset,
    input  logic        jump_type,
    input  logic [15:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] out_addr,
    output logic        err
);
    typedef enum logic [1:0] {EMPTY, WORD1, WORD2} state_t;
    state_t state;
    logic [15:0] enc, imm_q;
    logic legal, dbl, acc, out_hs;
    always_comb begin
        case (opcode)
            R_TYPE:  enc = {alu_op, rd, rs2, rs1, opcode};
            I_TYPE:  enc = {alu_op, rd, 3'd0, rs1, opcode};
            B_TYPE:  enc = {b_type, offset[3:0], rs2, rs1, opcode};
            J_TYPE:  enc = {offset[8:5], rd, offset[4:0], 1'b0, opcode};
            M_TYPE:  enc = {mem_op, rd, rs2, rs1, opcode};
            default: enc = {13'd0, opcode};
        endcase
    end
    // jump_type is not stored separately: it must agree with offset[2], which lands on bit 6
    assign legal = (opcode <= SYS_END) && !(opcode == B_TYPE && |offset[8:4])
                   && !(opcode == J_TYPE && jump_type != offset[2]);
    assign dbl = opcode == I_TYPE || opcode == M_TYPE;
    assign out_valid = state != EMPTY;
    assign in_ready = state == EMPTY || (out_last && out_ready);
    assign acc = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            out_word <= '0;
            out_first <= 1'b0;
            out_last <= 1'b0;
            out_addr <= START_ADDR;
            imm_q <= '0;
            err <= 1'b0;
        end else begin
            err <= acc && !legal;
            if (out_hs) out_addr <= out_addr + 16'd1;
            if (acc && legal) begin
                state <= WORD1;
                out_word <= enc;
                out_first <= 1'b1;
                out_last <= !dbl;
                imm_q <= imm;
            end else if (out_hs) begin
                // a rejected accept during the last word also lands here and empties the stage
                state <= out_last ? EMPTY : WORD2;
                out_word <= out_last ? 16'd0 : imm_q;
                out_first <= 1'b0;
                out_last <= !out_last;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: random and directed stimulus scored against a word-queue model of the encoder
module tb_instr_encoder;
    import instr_encoder_pkg::*;
    localparam logic [15:0] SA = 16'hFFFF;
    logic clock = 0, reset = 1, in_valid = 0, out_ready = 0, jump_type = 0;
    logic [2:0] opcode = 0, rd = 0, rs1 = 0, rs2 = 0, b_type = 0;
    logic [3:0] alu_op = 0, mem_op = 0;
    logic [8:0] offset = 0;
    logic [15:0] imm = 0;
    logic in_ready, out_valid, out_first, out_last, err;
    logic [15:0] out_word, out_addr;
    typedef struct packed {logic [15:0] w; logic f; logic l;} ent_t;
    ent_t q[$];
    logic [15:0] m_addr = SA;
    logic m_err = 0;
    int checks = 0, failures = 0;

    instr_encoder #(.START_ADDR(SA)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .alu_op(alu_op), .mem_op(mem_op),
        .b_type(b_type), .offset(offset), .jump_type(jump_type), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_first(out_first), .out_last(out_last), .out_addr(out_addr), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned word1();
        int unsigned o = opcode;
        case (opcode)
            R_TYPE:  return o + rs1 * 8 + rs2 * 64 + rd * 512 + alu_op * 4096;
            I_TYPE:  return o + rs1 * 8 + rd * 512 + alu_op * 4096;
            B_TYPE:  return o + rs1 * 8 + rs2 * 64 + (offset % 16) * 512 + b_type * 8192;
            J_TYPE:  return o + (offset % 32) * 16 + rd * 512 + (offset / 32) * 4096;
            M_TYPE:  return o + rs1 * 8 + rs2 * 64 + rd * 512 + mem_op * 4096;
            default: return o;
        endcase
    endfunction

    function automatic bit legal();
        if (opcode > 5) return 0;
        if (opcode == B_TYPE && offset >= 16) return 0;
        if (opcode == J_TYPE && int'(jump_type) != (offset / 4) % 2) return 0;
        return 1;
    endfunction

    task automatic instr(input logic [2:0] op, d, s1, s2, input logic [3:0] a, m,
                         input logic [2:0] bt, input logic [8:0] off, input logic jt,
                         input logic [15:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; alu_op = a; mem_op = m;
        b_type = bt; offset = off; jump_type = jt; imm = im;
    endtask

    // checks current outputs against the model, advances the model, then clocks once
    task automatic cyc();
        logic acc, ok;
        logic [15:0] w;
        #1;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() == 0 || (q.size() == 1 && out_ready));
        chk("out_addr", out_addr, m_addr);
        chk("err", err, m_err);
        if (q.size() != 0) begin
            chk("out_word", out_word, q[0].w);
            chk("out_first", out_first, q[0].f);
            chk("out_last", out_last, q[0].l);
        end
        if (reset) begin
            q.delete();
            m_addr = SA;
            m_err = 0;
        end else begin
            acc = in_valid && (q.size() == 0 || (q.size() == 1 && out_ready));
            ok = legal();
            w = 16'(word1());
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
                m_addr = m_addr + 16'd1;
            end
            m_err = acc && !ok;
            if (acc && ok) begin
                if (opcode == I_TYPE || opcode == M_TYPE) begin
                    q.push_back(ent_t'{w, 1'b1, 1'b0});
                    q.push_back(ent_t'{imm, 1'b0, 1'b1});
                end else q.push_back(ent_t'{w, 1'b1, 1'b1});
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", out_addr, SA);
        chk("rst_word", out_word, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        reset = 0;
        // R_TYPE single word, then a second single word to show the address wrap
        instr(R_TYPE, 3'd6, 3'd3, 3'd5, 4'hA, 4'h0, 3'd0, 9'd0, 1'b0, 16'h0);
        in_valid = 1; out_ready = 1;
        cyc();
        in_valid = 0;
        #1;
        chk("r_word", out_word, 16'hAD58);
        chk("r_first", out_first, 1);
        chk("r_last", out_last, 1);
        chk("r_addr", out_addr, SA);
        instr(SYS_END, 3'd0, 3'd0, 3'd0, 4'h0, 4'h0, 3'd0, 9'd0, 1'b0, 16'h0);
        in_valid = 1;
        cyc();
        in_valid = 0;
        #1;
        chk("wrap_addr", out_addr, 16'h0000);
        cyc();
        // M_TYPE held by back-pressure; fields change under it
        instr(M_TYPE, 3'd1, 3'd2, 3'd0, 4'h0, LW, 3'd0, 9'd0, 1'b0, 16'hBEEF);
        in_valid = 1; out_ready = 0;
        cyc();
        in_valid = 0;
        instr(R_TYPE, 3'd7, 3'd7, 3'd7, 4'hF, 4'hF, 3'd7, 9'h1FF, 1'b1, 16'h1234);
        #1;
        chk("m_word1", out_word, 16'h1214);
        repeat (3) cyc();
        out_ready = 1;
        cyc();
        #1;
        chk("m_imm", out_word, 16'hBEEF);
        cyc();
        cyc();
        // back-to-back B_TYPE stream
        for (int i = 0; i < 4; i++) begin
            instr(B_TYPE, 3'd0, 3'(i), 3'(i + 1), 4'h0, 4'h0, 3'(i), 9'(i * 3), 1'b0, 16'h0);
            in_valid = 1;
            cyc();
        end
        in_valid = 0;
        cyc();
        // two rejected instructions
        instr(J_TYPE, 3'd2, 3'd0, 3'd0, 4'h0, 4'h0, 3'd0, 9'h004, 1'b0, 16'h0);
        in_valid = 1;
        cyc();
        instr(B_TYPE, 3'd0, 3'd1, 3'd2, 4'h0, 4'h0, 3'd1, 9'h010, 1'b0, 16'h0);
        cyc();
        in_valid = 0;
        cyc();
        cyc();
        // reset while I_TYPE sits in its second word
        instr(I_TYPE, 3'd2, 3'd1, 3'd0, 4'h3, 4'h0, 3'd0, 9'd0, 1'b0, 16'h5A5A);
        in_valid = 1;
        cyc();
        in_valid = 0;
        cyc();
        out_ready = 0; reset = 1;
        cyc();
        reset = 0; out_ready = 1;
        repeat (3) cyc();
        // random traffic
        repeat (400) begin
            instr(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom),
                  4'($urandom), 3'($urandom), 9'($urandom), 1'($urandom), 16'($urandom));
            if (opcode == B_TYPE && $urandom % 2 == 0) offset = offset % 16;
            if (opcode == J_TYPE && $urandom % 2 == 0) jump_type = offset[2];
            in_valid = $urandom % 4 != 0;
            out_ready = $urandom % 4 != 0;
            reset = $urandom % 64 == 0;
            cyc();
        end
        reset = 0; in_valid = 0; out_ready = 1;
        repeat (4) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
